// File: rtl/muldiv_pkg.sv
// Shared constants and types for the multiply/divide sequencer.
// Holds the funct codes, the FSM state encoding and small operand helpers.
package muldiv_pkg;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  typedef enum logic {OP_MUL, OP_DIV} op_cls_t;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

  // mult/multu/div/divu share the 0110xx pattern
  function automatic logic is_iter(input logic [5:0] f);
    return f[5:2] == 4'b0110;
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Decoder/execute-side handshake for the multiply/divide sequencer.
// The master issues operations; the slave (muldiv_ctrl) returns status and HI/LO.
interface muldiv_if;
  logic        Md_start;
  logic [5:0]  Function_opcode;
  logic [31:0] Read_data_1;
  logic [31:0] Read_data_2;
  logic        Md_busy;
  logic        Md_done;
  logic        Div_by_zero;
  logic [31:0] Hi_out;
  logic [31:0] Lo_out;

  modport master (
    output Md_start, Function_opcode, Read_data_1, Read_data_2,
    input  Md_busy, Md_done, Div_by_zero, Hi_out, Lo_out
  );

  modport slave (
    input  Md_start, Function_opcode, Read_data_1, Read_data_2,
    output Md_busy, Md_done, Div_by_zero, Hi_out, Lo_out
  );
endinterface

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring shift-subtract divide.
// acc holds {upper, lower} halves; for divide the new quotient bit is returned separately.
module muldiv_step
  import muldiv_pkg::*;
(
  input  logic [63:0] acc,
  input  logic [31:0] opnd,
  input  op_cls_t     op,
  output logic [63:0] acc_nxt,
  output logic        q_bit
);

  logic [32:0] sum;
  logic [32:0] rem_sh;
  logic [31:0] diff;

  always_comb begin
    acc_nxt = acc;
    q_bit   = 1'b0;
    sum     = '0;
    rem_sh  = '0;
    diff    = '0;
    if (op == OP_MUL) begin
      sum     = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
      acc_nxt = {sum, acc[31:1]};
    end else begin
      // when the subtract succeeds the result is below the divisor, so 32 bits suffice
      rem_sh  = acc[63:31];
      diff    = rem_sh[31:0] - opnd;
      q_bit   = rem_sh >= {1'b0, opnd};
      acc_nxt = {(q_bit ? diff : rem_sh[31:0]), acc[30:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle multiply/divide sequencer with architectural HI/LO registers.
// Iterates STEPS cycles in RUN, then applies sign fix-up and writes HI/LO in FIX.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int STEPS = 32
) (
  input  logic     clock,
  input  logic     reset,
  muldiv_if.slave  bus
);

  localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [63:0]   acc, step_acc;
  logic          step_q;
  logic [31:0]   opnd, hi, lo;
  op_cls_t       op;
  logic          sgn_res, sgn_rem, dz;
  logic          done_q, dz_q;

  logic          accept, start_div, start_sgn, rt_zero;
  logic [31:0]   rs_abs, rt_abs;
  logic [63:0]   prod_fix;
  logic [31:0]   quo_fix, rem_fix;

  assign accept    = (state == IDLE) && bus.Md_start && is_iter(bus.Function_opcode);
  assign start_div = bus.Function_opcode[1];
  assign start_sgn = ~bus.Function_opcode[0];
  assign rt_zero   = bus.Read_data_2 == 32'd0;
  assign rs_abs    = start_sgn ? abs32(bus.Read_data_1) : bus.Read_data_1;
  assign rt_abs    = start_sgn ? abs32(bus.Read_data_2) : bus.Read_data_2;

  assign prod_fix  = sgn_res ? (~acc + 64'd1) : acc;
  assign quo_fix   = sgn_res ? (~acc[31:0] + 32'd1) : acc[31:0];
  assign rem_fix   = sgn_rem ? (~acc[63:32] + 32'd1) : acc[63:32];

  muldiv_step u_step (
    .acc     (acc),
    .opnd    (opnd),
    .op      (op),
    .acc_nxt (step_acc),
    .q_bit   (step_q)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (start_div && rt_zero) ? FIX : RUN;
      RUN:  if (cnt == CW'(STEPS - 1)) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt     <= '0;
      acc     <= '0;
      opnd    <= '0;
      op      <= OP_MUL;
      sgn_res <= 1'b0;
      sgn_rem <= 1'b0;
      dz      <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            cnt     <= '0;
            op      <= start_div ? OP_DIV : OP_MUL;
            sgn_res <= start_sgn & (bus.Read_data_1[31] ^ bus.Read_data_2[31]);
            sgn_rem <= start_sgn & bus.Read_data_1[31];
            dz      <= start_div & rt_zero;
            // divide-by-zero keeps raw rs in the low half so FIX can return it in HI
            if (start_div) begin
              acc  <= {32'd0, rt_zero ? bus.Read_data_1 : rs_abs};
              opnd <= rt_abs;
            end else begin
              acc  <= {32'd0, rt_abs};
              opnd <= rs_abs;
            end
          end else if (bus.Md_start && bus.Function_opcode == F_MTHI) begin
            hi <= bus.Read_data_1;
          end else if (bus.Md_start && bus.Function_opcode == F_MTLO) begin
            lo <= bus.Read_data_1;
          end
        end
        RUN: begin
          acc <= step_acc | {63'd0, step_q};
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          done_q <= 1'b1;
          dz_q   <= dz;
          if (dz) begin
            hi <= acc[31:0];
            lo <= '1;
          end else if (op == OP_MUL) begin
            hi <= prod_fix[63:32];
            lo <= prod_fix[31:0];
          end else begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.Md_busy     = state != IDLE;
  assign bus.Md_done     = done_q;
  assign bus.Div_by_zero = dz_q;
  assign bus.Hi_out      = hi;
  assign bus.Lo_out      = lo;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: spec vectors, corner sequences, then random ops vs an arithmetic model.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;

  muldiv_if bus();

  muldiv_ctrl #(.STEPS(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  logic [31:0] mhi = '0, mlo = '0;

  typedef struct {
    logic [5:0]  f;
    logic [31:0] a, b, hi, lo;
    bit          dz;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic void model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                inout logic [31:0] hi, inout logic [31:0] lo,
                                output bit dz, output int bc, output bit dn);
    longint sa, sb, r;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 0; bc = 0; dn = 0;
    case (f)
      F_MULT:  begin r = sa * sb; hi = r[63:32]; lo = r[31:0]; bc = 33; dn = 1; end
      F_MULTU: begin u = {32'd0, a} * {32'd0, b}; hi = u[63:32]; lo = u[31:0]; bc = 33; dn = 1; end
      F_DIV, F_DIVU: begin
        dn = 1;
        if (b == 0) begin
          hi = a; lo = 32'hFFFF_FFFF; dz = 1; bc = 1;
        end else begin
          bc = 33;
          if (f == F_DIV) begin
            r = sa / sb; lo = r[31:0];
            r = sa % sb; hi = r[31:0];
          end else begin
            lo = a / b; hi = a % b;
          end
        end
      end
      F_MTHI: hi = a;
      F_MTLO: lo = a;
      default: ;
    endcase
  endfunction

  // caller is at a negedge; returns at the negedge where Md_busy is low again
  task automatic do_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo,
                       output bit dz, output int bc, output bit dn);
    bus.Md_start = 1'b1; bus.Function_opcode = f;
    bus.Read_data_1 = a; bus.Read_data_2 = b;
    @(negedge clock);
    bus.Md_start = 1'b0;
    bc = 0;
    while (bus.Md_busy && bc < 100) begin
      bc++;
      @(negedge clock);
    end
    hi = bus.Hi_out; lo = bus.Lo_out; dz = bus.Div_by_zero; dn = bus.Md_done;
  endtask

  task automatic exec(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                      output logic [31:0] hi, output logic [31:0] lo, output bit dz);
    bit edz, dn, edn;
    int bc, ebc;
    do_op(f, a, b, hi, lo, dz, bc, dn);
    model(f, a, b, mhi, mlo, edz, ebc, edn);
    chk("model_hi", {32'd0, hi}, {32'd0, mhi});
    chk("model_lo", {32'd0, lo}, {32'd0, mlo});
    chk("model_dz", {63'd0, dz}, {63'd0, edz});
    chk("busy_cycles", 64'(bc), 64'(ebc));
    chk("done_pulse", {63'd0, dn}, {63'd0, edn});
  endtask

  initial begin
    vec_t tbl[8];
    logic [31:0] hi, lo;
    bit dz;
    int n;
    bit saw_done;

    tbl[0] = '{F_MULT,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, 0};
    tbl[1] = '{F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0};
    tbl[2] = '{F_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 0};
    tbl[3] = '{F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0};
    tbl[4] = '{F_DIVU,  32'h0000_1234, 32'd0,        32'h0000_1234, 32'hFFFF_FFFF, 1};
    tbl[5] = '{F_DIVU,  32'd100,       32'd7,        32'd2,         32'd14,        0};
    tbl[6] = '{F_MULT,  32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0};
    tbl[7] = '{F_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 0};

    bus.Md_start = 1'b0; bus.Function_opcode = '0;
    bus.Read_data_1 = '0; bus.Read_data_2 = '0;
    repeat (2) @(negedge clock);
    chk("rst_busy", {63'd0, bus.Md_busy}, 64'd0);
    chk("rst_done", {63'd0, bus.Md_done}, 64'd0);
    chk("rst_dz",   {63'd0, bus.Div_by_zero}, 64'd0);
    chk("rst_hilo", {bus.Hi_out, bus.Lo_out}, 64'd0);
    reset = 1'b0;
    @(negedge clock);

    // consecutive entries issue in the Md_done cycle, exercising back-to-back starts
    for (int i = 0; i < 8; i++) begin
      exec(tbl[i].f, tbl[i].a, tbl[i].b, hi, lo, dz);
      chk($sformatf("vec%0d_hi", i), {32'd0, hi}, {32'd0, tbl[i].hi});
      chk($sformatf("vec%0d_lo", i), {32'd0, lo}, {32'd0, tbl[i].lo});
      chk($sformatf("vec%0d_dz", i), {63'd0, dz}, {63'd0, tbl[i].dz});
    end
    @(negedge clock);
    chk("done_one_cycle", {63'd0, bus.Md_done}, 64'd0);
    chk("dz_one_cycle",   {63'd0, bus.Div_by_zero}, 64'd0);

    // mthi while idle: visible next cycle, no stall
    exec(F_MTHI, 32'hA5A5_A5A5, 32'd0, hi, lo, dz);
    chk("mthi_hi", {32'd0, bus.Hi_out}, 64'h0000_0000_A5A5_A5A5);
    chk("mthi_busy", {63'd0, bus.Md_busy}, 64'd0);
    exec(F_MTLO, 32'h5A5A_0F0F, 32'd0, hi, lo, dz);

    // mthi during RUN must be ignored and HI/LO hold their old values
    bus.Md_start = 1'b1; bus.Function_opcode = F_MULT;
    bus.Read_data_1 = 32'd2; bus.Read_data_2 = 32'd3;
    @(negedge clock);
    bus.Md_start = 1'b0;
    repeat (5) @(negedge clock);
    bus.Md_start = 1'b1; bus.Function_opcode = F_MTHI; bus.Read_data_1 = 32'hDEAD_BEEF;
    @(negedge clock);
    bus.Md_start = 1'b0;
    chk("run_hi_hold", {32'd0, bus.Hi_out}, 64'h0000_0000_A5A5_A5A5);
    chk("run_lo_hold", {32'd0, bus.Lo_out}, 64'h0000_0000_5A5A_0F0F);
    n = 0;
    while (bus.Md_busy && n < 100) begin n++; @(negedge clock); end
    chk("busy_ign_bound", {63'd0, bus.Md_busy}, 64'd0);
    chk("busy_ign_hilo", {bus.Hi_out, bus.Lo_out}, 64'd6);
    mhi = 32'd0; mlo = 32'd6;

    // reset in the middle of RUN aborts without Md_done
    bus.Md_start = 1'b1; bus.Function_opcode = F_DIVU;
    bus.Read_data_1 = 32'd1000; bus.Read_data_2 = 32'd3;
    @(negedge clock);
    bus.Md_start = 1'b0;
    repeat (10) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("abort_busy", {63'd0, bus.Md_busy}, 64'd0);
    chk("abort_hilo", {bus.Hi_out, bus.Lo_out}, 64'd0);
    saw_done = 1'b0;
    repeat (40) begin
      if (bus.Md_done || bus.Md_busy) saw_done = 1'b1;
      @(negedge clock);
    end
    chk("abort_no_done", {63'd0, saw_done}, 64'd0);
    mhi = '0; mlo = '0;

    for (int i = 0; i < 40; i++) begin
      logic [5:0] f;
      logic [31:0] a, b;
      case ($urandom_range(0, 5))
        0: f = F_MULT;  1: f = F_MULTU; 2: f = F_DIV;
        3: f = F_DIVU;  4: f = F_MTHI;  default: f = F_MTLO;
      endcase
      a = $urandom();
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom() >> $urandom_range(0, 31);
      if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
      if ($urandom_range(0, 9) == 0) b = 32'hFFFF_FFFF;
      exec(f, a, b, hi, lo, dz);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
